arena_move_sequencer: RTL and testbench



---
 rtl/bombman_pkg.sv | 47 ++++
 rtl/rr_arb2.sv | 38 +++
 rtl/arena_move_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_arena_move_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bombman_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bombman_pkg
//  Description : Shared constants, command encoding, FSM state codes and the
//                grid address helper for the arena move sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package bombman_pkg;

    // Cells per grid side; cell address = x*GRID + y (x = row, y = column)
    localparam int GRID = 10;

    // Arena cell codes
    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_WALL  = 2'd1;
    localparam logic [1:0] CELL_PA    = 2'd2;
    localparam logic [1:0] CELL_PB    = 2'd3;

    // Bomb cell codes
    localparam logic [1:0] BOMB_NONE  = 2'd0;
    localparam logic [1:0] BOMB_NEW   = 2'd3;

    // Player commands; encodings 5..7 are reserved
    typedef enum logic [2:0] {
        CMD_UP    = 3'd0,
        CMD_DOWN  = 3'd1,
        CMD_LEFT  = 3'd2,
        CMD_RIGHT = 3'd3,
        CMD_BOMB  = 3'd4
    } cmd_e;

    // Sequencer FSM state codes
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_WR_NEW = 3'd3;
    localparam logic [2:0] ST_WR_OLD = 3'd4;

    // Linear cell address in 7 bits
    function automatic logic [6:0] cell_addr(input logic [3:0] x,
                                             input logic [3:0] y,
                                             input int         grid);
        return (7'(x) * 7'(grid)) + 7'(y);
    endfunction

endpackage : bombman_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter. When both requesters are active
//                the one not granted most recently wins. The priority pointer
//                only moves when advance is high (a grant was taken).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 0 = requester 0 has priority, 1 = requester 1 has priority
    logic r_prio_1;

    // Grant selection: single requester wins outright, contention uses pointer
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = r_prio_1 ? 2'b10 : 2'b01;
        end
    end

    // Pointer hands priority to the requester that was not just served
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio_1 <= 1'b0;
        end else if (advance) begin
            r_prio_1 <= grant[0];
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/arena_move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : arena_move_sequencer
//  Description : Serialises player A / player B move and bomb requests onto
//                the shared arena/bomb grid. Round-robin arbitration, then a
//                read-check-write sequence against the registered-read grid
//                memory, with both player positions tracked locally.
//  Revision    : 1.0 - initial release
// ============================================================================
module arena_move_sequencer
    import bombman_pkg::*;
#(
    parameter logic [3:0] AX0 = 4'd0,
    parameter logic [3:0] AY0 = 4'd0,
    parameter logic [3:0] BX0 = 4'd9,
    parameter logic [3:0] BY0 = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       a_valid,
    input  logic [2:0] a_cmd,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [2:0] b_cmd,
    output logic       b_ready,
    output logic [6:0] rd_addr,
    input  logic [1:0] rd_arena,
    input  logic [1:0] rd_bomb,
    output logic [6:0] wr_addr,
    output logic       wr_arena_en,
    output logic [1:0] wr_arena,
    output logic       wr_bomb_en,
    output logic [1:0] wr_bomb,
    output logic [3:0] pos_ax,
    output logic [3:0] pos_ay,
    output logic [3:0] pos_bx,
    output logic [3:0] pos_by,
    output logic       done,
    output logic       done_player,
    output logic       done_ok
);

    localparam logic [3:0] c_LAST = 4'(GRID - 1);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [2:0] r_state;
    logic       r_player;      // 0 = A, 1 = B for the request in flight
    logic       r_is_bomb;
    logic [3:0] r_tx;
    logic [3:0] r_ty;
    logic [6:0] r_taddr;       // target cell of a move
    logic [6:0] r_oaddr;       // own (old) cell of the requester
    logic [6:0] r_rd_addr;
    logic       r_quick_done;  // immediate reject (off-grid / reserved)
    logic [3:0] r_ax;
    logic [3:0] r_ay;
    logic [3:0] r_bx;
    logic [3:0] r_by;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [1:0] w_req;
    logic [1:0] w_grant;
    logic       w_gnt;
    logic       w_gplayer;
    logic [2:0] w_gcmd;
    logic [3:0] w_ox;
    logic [3:0] w_oy;
    logic [3:0] w_tx;
    logic [3:0] w_ty;
    logic       w_offgrid;
    logic       w_reserved;
    logic       w_is_bomb;
    logic [6:0] w_taddr;
    logic [6:0] w_oaddr;
    logic       w_move_ok;
    logic       w_bomb_ok;

    // Requests are only visible to the arbiter while idle and enabled, so
    // ready can never rise mid-sequence and a held request is never lost.
    assign w_req = (r_state == ST_IDLE && enable && !rst) ? {b_valid, a_valid} : 2'b00;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .advance (w_gnt),
        .grant   (w_grant)
    );

    assign w_gnt     = |w_grant;
    assign w_gplayer = w_grant[1];
    assign w_gcmd    = w_gplayer ? b_cmd : a_cmd;
    assign w_ox      = w_gplayer ? r_bx : r_ax;
    assign w_oy      = w_gplayer ? r_by : r_ay;
    assign w_is_bomb = (w_gcmd == CMD_BOMB);

    // Target coordinate; edge tests happen before any subtract/add so the
    // 4-bit coordinates never wrap.
    always_comb begin
        w_tx       = w_ox;
        w_ty       = w_oy;
        w_offgrid  = 1'b0;
        w_reserved = 1'b0;
        case (w_gcmd)
            CMD_UP: begin
                if (w_ox == 4'd0) w_offgrid = 1'b1;
                else              w_tx = w_ox - 4'd1;
            end
            CMD_DOWN: begin
                if (w_ox >= c_LAST) w_offgrid = 1'b1;
                else                w_tx = w_ox + 4'd1;
            end
            CMD_LEFT: begin
                if (w_oy == 4'd0) w_offgrid = 1'b1;
                else              w_ty = w_oy - 4'd1;
            end
            CMD_RIGHT: begin
                if (w_oy >= c_LAST) w_offgrid = 1'b1;
                else                w_ty = w_oy + 4'd1;
            end
            CMD_BOMB: begin
                w_tx = w_ox;
            end
            default: begin
                w_reserved = 1'b1;
            end
        endcase
    end

    assign w_taddr   = cell_addr(w_tx, w_ty, GRID);
    assign w_oaddr   = cell_addr(w_ox, w_oy, GRID);
    assign w_move_ok = (rd_arena == CELL_EMPTY) && (rd_bomb == BOMB_NONE);
    assign w_bomb_ok = (rd_bomb == BOMB_NONE);

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign a_ready     = w_grant[0];
    assign b_ready     = w_grant[1];
    assign rd_addr     = r_rd_addr;
    assign pos_ax      = r_ax;
    assign pos_ay      = r_ay;
    assign pos_bx      = r_bx;
    assign pos_by      = r_by;
    assign done_player = r_player;

    // Write strobes and completion flags decoded from the current state
    always_comb begin
        wr_addr     = 7'd0;
        wr_arena_en = 1'b0;
        wr_arena    = CELL_EMPTY;
        wr_bomb_en  = 1'b0;
        wr_bomb     = BOMB_NONE;
        done        = r_quick_done;
        done_ok     = 1'b0;
        case (r_state)
            ST_CHECK: begin
                if (r_is_bomb) begin
                    done = 1'b1;
                    if (w_bomb_ok) begin
                        wr_bomb_en = 1'b1;
                        wr_bomb    = BOMB_NEW;
                        wr_addr    = r_oaddr;
                        done_ok    = 1'b1;
                    end
                end else if (!w_move_ok) begin
                    done = 1'b1;
                end
            end
            ST_WR_NEW: begin
                wr_arena_en = 1'b1;
                wr_addr     = r_taddr;
                wr_arena    = r_player ? CELL_PB : CELL_PA;
            end
            ST_WR_OLD: begin
                wr_arena_en = 1'b1;
                wr_addr     = r_oaddr;
                wr_arena    = CELL_EMPTY;
                done        = 1'b1;
                done_ok     = 1'b1;
            end
            default: begin
                wr_arena_en = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM: grant, fetch, check, write new cell, clear old cell
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_player     <= 1'b0;
            r_is_bomb    <= 1'b0;
            r_tx         <= 4'd0;
            r_ty         <= 4'd0;
            r_taddr      <= 7'd0;
            r_oaddr      <= 7'd0;
            r_rd_addr    <= 7'd0;
            r_quick_done <= 1'b0;
            r_ax         <= AX0;
            r_ay         <= AY0;
            r_bx         <= BX0;
            r_by         <= BY0;
        end else begin
            r_quick_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt) begin
                        r_player  <= w_gplayer;
                        r_is_bomb <= w_is_bomb;
                        r_tx      <= w_tx;
                        r_ty      <= w_ty;
                        r_taddr   <= w_taddr;
                        r_oaddr   <= w_oaddr;
                        if (w_offgrid || w_reserved) begin
                            // Rejected without touching the grid
                            r_quick_done <= 1'b1;
                        end else begin
                            r_rd_addr <= w_is_bomb ? w_oaddr : w_taddr;
                            r_state   <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (!r_is_bomb && w_move_ok) r_state <= ST_WR_NEW;
                    else                         r_state <= ST_IDLE;
                end
                ST_WR_NEW: begin
                    r_state <= ST_WR_OLD;
                end
                ST_WR_OLD: begin
                    if (r_player) begin
                        r_bx <= r_tx;
                        r_by <= r_ty;
                    end else begin
                        r_ax <= r_tx;
                        r_ay <= r_ty;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : arena_move_sequencer
`default_nettype wire

// File: tb/tb_arena_move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arena_move_sequencer
//  Description : Scoreboard bench for arena_move_sequencer with a behavioural
//                registered-read grid memory. Stimulus pushes expected
//                completions and grid writes; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arena_move_sequencer;

    typedef struct {
        bit pl;
        bit ok;
        int lat;
    } done_t;

    typedef struct {
        bit         is_bomb;
        logic [6:0] addr;
        logic [1:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       a_valid;
    logic [2:0] a_cmd;
    logic       a_ready;
    logic       b_valid;
    logic [2:0] b_cmd;
    logic       b_ready;
    logic [6:0] rd_addr;
    logic [1:0] rd_arena;
    logic [1:0] rd_bomb;
    logic [6:0] wr_addr;
    logic       wr_arena_en;
    logic [1:0] wr_arena;
    logic       wr_bomb_en;
    logic [1:0] wr_bomb;
    logic [3:0] pos_ax;
    logic [3:0] pos_ay;
    logic [3:0] pos_bx;
    logic [3:0] pos_by;
    logic       done;
    logic       done_player;
    logic       done_ok;

    logic [1:0] arena [128];
    logic [1:0] bomb  [128];

    done_t exp_done_q[$];
    wr_t   exp_wr_q[$];
    int    gq[$];
    bit    gorder[$];
    int    cyc    = 0;
    int    checks = 0;
    int    passes = 0;

    arena_move_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .a_valid     (a_valid),
        .a_cmd       (a_cmd),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_cmd       (b_cmd),
        .b_ready     (b_ready),
        .rd_addr     (rd_addr),
        .rd_arena    (rd_arena),
        .rd_bomb     (rd_bomb),
        .wr_addr     (wr_addr),
        .wr_arena_en (wr_arena_en),
        .wr_arena    (wr_arena),
        .wr_bomb_en  (wr_bomb_en),
        .wr_bomb     (wr_bomb),
        .pos_ax      (pos_ax),
        .pos_ay      (pos_ay),
        .pos_bx      (pos_bx),
        .pos_by      (pos_by),
        .done        (done),
        .done_player (done_player),
        .done_ok     (done_ok)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Grid memory: registered read, write-enable per plane
    always @(posedge clk) begin
        rd_arena <= arena[rd_addr];
        rd_bomb  <= bomb[rd_addr];
        if (wr_arena_en) arena[wr_addr] <= wr_arena;
        if (wr_bomb_en)  bomb[wr_addr]  <= wr_bomb;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic note_fail(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: compares every completion and grid write against the queues
    always @(negedge clk) begin
        if (rst) begin
            gq.delete();
        end else begin
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    note_fail("done_unexpected", {31'd0, done}, 0);
                end else begin
                    done_t e;
                    int    g;
                    e = exp_done_q.pop_front();
                    g = (gq.size() != 0) ? gq.pop_front() : -1000;
                    chk("done_player", {31'd0, done_player}, {31'd0, e.pl});
                    chk("done_ok", {31'd0, done_ok}, {31'd0, e.ok});
                    chk("done_latency", cyc - g, e.lat);
                end
            end
            if (wr_arena_en) begin
                if (exp_wr_q.size() == 0) begin
                    note_fail("wr_arena_unexpected", {25'd0, wr_addr}, 0);
                end else begin
                    wr_t w;
                    w = exp_wr_q.pop_front();
                    chk("wr_arena", {22'd0, 1'b0, wr_addr, wr_arena},
                        {22'd0, w.is_bomb, w.addr, w.data});
                end
            end
            if (wr_bomb_en) begin
                if (exp_wr_q.size() == 0) begin
                    note_fail("wr_bomb_unexpected", {25'd0, wr_addr}, 0);
                end else begin
                    wr_t w;
                    w = exp_wr_q.pop_front();
                    chk("wr_bomb", {22'd0, 1'b1, wr_addr, wr_bomb},
                        {22'd0, w.is_bomb, w.addr, w.data});
                end
            end
            if (a_ready) gq.push_back(cyc);
            if (b_ready) gq.push_back(cyc);
        end
    end

    task automatic exp_done(input bit pl, input bit ok, input int lat);
        done_t e;
        e.pl = pl; e.ok = ok; e.lat = lat;
        exp_done_q.push_back(e);
    endtask

    task automatic exp_wr(input bit is_bomb, input logic [6:0] addr, input logic [1:0] data);
        wr_t w;
        w.is_bomb = is_bomb; w.addr = addr; w.data = data;
        exp_wr_q.push_back(w);
    endtask

    // Present one request and hold it until accepted
    task automatic issue(input bit pl, input logic [2:0] cmd);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        @(posedge clk); #1;
        if (pl) begin b_valid = 1'b1; b_cmd = cmd; end
        else    begin a_valid = 1'b1; a_cmd = cmd; end
        while (!got && n < 50) begin
            @(negedge clk);
            got = pl ? b_ready : a_ready;
            n++;
        end
        if (!got) note_fail("ready_timeout", 0, 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Both players hold requests; n per player, commands c0 then c1
    task automatic dual(input int n, input logic [2:0] ac0, input logic [2:0] ac1,
                        input logic [2:0] bc0, input logic [2:0] bc1);
        int na, nb, k;
        bit ga, gb;
        na = 0; nb = 0; k = 0;
        @(posedge clk); #1;
        a_valid = 1'b1; a_cmd = ac0;
        b_valid = 1'b1; b_cmd = bc0;
        while ((na < n || nb < n) && k < 200) begin
            @(negedge clk);
            ga = a_ready; gb = b_ready; k++;
            if (ga) gorder.push_back(1'b0);
            if (gb) gorder.push_back(1'b1);
            @(posedge clk); #1;
            if (ga) begin na++; if (na >= n) a_valid = 1'b0; else a_cmd = ac1; end
            if (gb) begin nb++; if (nb >= n) b_valid = 1'b0; else b_cmd = bc1; end
        end
        if (k >= 200) note_fail("dual_timeout", na + nb, 2 * n);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Wait for all expectations to drain, then settle two cycles
    task automatic wait_quiet();
        int n;
        n = 0;
        while ((exp_done_q.size() != 0 || exp_wr_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            note_fail("drain_timeout", exp_done_q.size() + exp_wr_q.size(), 0);
            exp_done_q.delete();
            exp_wr_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_pos(input string name, input logic [3:0] ax, input logic [3:0] ay,
                           input logic [3:0] bx, input logic [3:0] by);
        chk(name, {16'd0, pos_ax, pos_ay, pos_bx, pos_by}, {16'd0, ax, ay, bx, by});
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            arena[i] = 2'd0;
            bomb[i]  = 2'd0;
        end
        rst = 1'b1; enable = 1'b1;
        a_valid = 1'b0; a_cmd = 3'd0;
        b_valid = 1'b0; b_cmd = 3'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk_pos("reset_pos", 4'd0, 4'd0, 4'd9, 4'd9);
        chk("reset_strobes", {28'd0, a_ready, b_ready, wr_arena_en, wr_bomb_en}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_addr", {18'd0, rd_addr, wr_addr}, 0);

        // Disabled: valid is held but nothing is granted
        enable = 1'b0; a_valid = 1'b1; a_cmd = 3'd1;
        @(negedge clk);
        chk("disabled_ready", {31'd0, a_ready}, 0);
        @(negedge clk);
        chk("disabled_ready2", {31'd0, a_ready}, 0);
        a_valid = 1'b0; enable = 1'b1;

        // A moves down (0,0)->(1,0)
        exp_wr(1'b0, 7'd10, 2'd2);
        exp_wr(1'b0, 7'd0, 2'd0);
        exp_done(1'b0, 1'b1, 4);
        issue(1'b0, 3'd1);
        wait_quiet();
        chk_pos("pos_after_down", 4'd1, 4'd0, 4'd9, 4'd9);

        // A moves up back to (0,0), then off-grid up/left, then reserved
        exp_wr(1'b0, 7'd0, 2'd2);
        exp_wr(1'b0, 7'd10, 2'd0);
        exp_done(1'b0, 1'b1, 4);
        issue(1'b0, 3'd0);
        exp_done(1'b0, 1'b0, 1);
        issue(1'b0, 3'd0);
        exp_done(1'b0, 1'b0, 1);
        issue(1'b0, 3'd2);
        exp_done(1'b0, 1'b0, 1);
        issue(1'b0, 3'd5);
        wait_quiet();
        chk_pos("pos_after_offgrid", 4'd0, 4'd0, 4'd9, 4'd9);

        // Wall at (0,1) and bomb at (1,0) block A
        arena[1] = 2'd1;
        bomb[10] = 2'd3;
        exp_done(1'b0, 1'b0, 2);
        issue(1'b0, 3'd3);
        exp_done(1'b0, 1'b0, 2);
        issue(1'b0, 3'd1);
        wait_quiet();
        chk_pos("pos_after_blocked", 4'd0, 4'd0, 4'd9, 4'd9);
        arena[1] = 2'd0;
        bomb[10] = 2'd0;

        // B places a bomb twice, then tries off-grid right and down
        exp_wr(1'b1, 7'd99, 2'd3);
        exp_done(1'b1, 1'b1, 2);
        issue(1'b1, 3'd4);
        exp_done(1'b1, 1'b0, 2);
        issue(1'b1, 3'd4);
        exp_done(1'b1, 1'b0, 1);
        issue(1'b1, 3'd3);
        exp_done(1'b1, 1'b0, 1);
        issue(1'b1, 3'd1);
        wait_quiet();
        chk("bomb_cell_99", {30'd0, bomb[99]}, 3);

        // Contention: grants alternate A,B,A,B
        exp_wr(1'b0, 7'd10, 2'd2); exp_wr(1'b0, 7'd0, 2'd0);  exp_done(1'b0, 1'b1, 4);
        exp_wr(1'b0, 7'd89, 2'd3); exp_wr(1'b0, 7'd99, 2'd0); exp_done(1'b1, 1'b1, 4);
        exp_wr(1'b0, 7'd20, 2'd2); exp_wr(1'b0, 7'd10, 2'd0); exp_done(1'b0, 1'b1, 4);
        exp_wr(1'b0, 7'd88, 2'd3); exp_wr(1'b0, 7'd89, 2'd0); exp_done(1'b1, 1'b1, 4);
        gorder.delete();
        dual(2, 3'd1, 3'd1, 3'd0, 3'd2);
        wait_quiet();
        chk("rr_order", {28'd0, (gorder.size() == 4) ? {gorder[0], gorder[1], gorder[2], gorder[3]} : 4'hF},
            {28'd0, 4'b0101});
        chk_pos("pos_after_dual", 4'd2, 4'd0, 4'd8, 4'd8);

        // Reset while in WR_NEW of A's move (2,0)->(3,0)
        issue(1'b0, 3'd1);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("in_wr_new", {24'd0, wr_arena_en, wr_addr}, {24'd0, 1'b1, 7'd30});
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_strobes", {29'd0, wr_arena_en, done, a_ready}, 0);
        chk_pos("rst_pos", 4'd0, 4'd0, 4'd9, 4'd9);

        // Arbiter pointer back at A after reset; B's bomb cell is occupied
        exp_wr(1'b0, 7'd10, 2'd2); exp_wr(1'b0, 7'd0, 2'd0); exp_done(1'b0, 1'b1, 4);
        exp_done(1'b1, 1'b0, 2);
        gorder.delete();
        dual(1, 3'd1, 3'd1, 3'd4, 3'd4);
        wait_quiet();
        chk("rr_after_rst", {30'd0, (gorder.size() == 2) ? {gorder[0], gorder[1]} : 2'b11},
            {30'd0, 2'b01});
        chk_pos("pos_final", 4'd1, 4'd0, 4'd9, 4'd9);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global guard against a stalled run
    initial begin
        #200000;
        $display("FAIL global_timeout: actual=%0d required=0", cyc);
        $fatal(1);
    end

endmodule : tb_arena_move_sequencer
`default_nettype wire
